sram_axi_bridge_arb: RTL and testbench
======================================

Name: sram_axi_bridge_arb

Overview:
- Arbitrates the instruction-fetch and MEM-stage data SRAM-like interfaces onto one AXI3/4 master port.
- Converts req/addr_ok/data_ok handshakes into AR/R and AW/W/B transactions.
- Sits between the CPU core and the top-level AXI wrapper.
- At most one read and one write are outstanding at a time. Data accesses have read priority over fetch.

Parameters:
- ARID_INST, 4'd0, AXI ID used for instruction reads.
- ARID_DATA, 4'd1, AXI ID used for data reads; also the AWID.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request; always a read
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid, 1-cycle pulse
- inst_rdata  out  32  fetch data
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_size  in  2  access size
- data_wstrb  in  4  byte enables
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid or store complete, 1-cycle pulse
- data_rdata  out  32  load data
- arid  out  4  read ID
- araddr  out  32  read address
- arsize  out  3  {1'b0, size}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  read-data ID
- rdata  in  32  read data
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  32  write address
- awsize  out  3  {1'b0, size}
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bvalid  in  1  B valid
- bready  out  1  B ready

Fixed AXI fields are not ports of this block; the wrapper drives them as constants: len=0, burst=INCR, lock/cache/prot=0, wlast=1, wid/awid=1.

Behaviour:

Reset (resetn=0 at a clk edge):
- Both FSMs go to IDLE.
- All valid, ready, addr_ok and data_ok outputs are 0.
- Address/data registers are cleared to 0.

Read FSM: R_IDLE -> R_AR -> R_WAIT -> R_IDLE.
- In R_IDLE, a read is selected combinationally:
  - data read (data_req & ~data_wr) wins if the write FSM is W_IDLE;
  - otherwise inst_req is selected.
- Selected requester gets addr_ok=1 in the same cycle.
- Next state is R_AR, latching addr, size, ID and an owner bit.
- R_AR: arvalid=1 with latched values. On arready -> R_WAIT. arvalid must stay stable until arready.
- R_WAIT: rready=1. On rvalid:
  - owner is taken from rid (ARID_INST/ARID_DATA);
  - pulse that owner's data_ok for one cycle;
  - drive its rdata from AXI rdata combinationally in that cycle;
  - go to R_IDLE.
- The rdata outputs of the non-owner are don't-care.
- A new read is not accepted in the cycle R_WAIT completes; the earliest next addr_ok is the following cycle.

Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_IDLE.
- In W_IDLE, a write (data_req & data_wr) is accepted (data_addr_ok=1) only if the read FSM does not hold a data read (owner≠data or R_IDLE).
- On acceptance, latch addr, size, wstrb and wdata, and go to W_ADDR.
- W_ADDR: awvalid and wvalid are raised together and cleared independently:
  - each drops on its own ready;
  - when both have handshaken (same or different cycles) -> W_RESP.
- W_RESP: bready=1. On bvalid, pulse data_data_ok for one cycle and go to W_IDLE.

Hazard rules:
- A data read is never issued while a write is outstanding (RAW through memory).
- data_addr_ok is never asserted for a read and a write in the same cycle.
- inst_addr_ok and data_addr_ok (read) are mutually exclusive.

Other rules:
- Requesters hold req and payload until addr_ok. The bridge does not cancel a request once it is accepted.
- data_ok ordering per requester is in acceptance order (trivially true with one outstanding read).
- Reset mid-transaction drops all state immediately. AXI valids fall to 0 on the next edge, and any in-flight response is ignored.

Test Plan:
- Inst read: inst_req=1, addr=0x1c000000, arready=1, rvalid 3 cycles later with rdata=0x02800C0C -> inst_addr_ok same cycle, arid=0, inst_data_ok=1 for exactly one cycle with inst_rdata=0x02800C0C.
- Simultaneous inst and data read, addr 0x1c000004 and 0x00001000 -> data wins (arid=1, araddr=0x1000); inst_addr_ok=0 until the data R handshake; then inst issues with arid=0.
- Store with awready delayed 2 cycles and wready immediate: wstrb=4'b0011, wdata=0x1234ABCD -> wvalid drops after 1 cycle, awvalid held 3 cycles, data_data_ok pulses one cycle after bvalid handshake.
- Load during an outstanding store to 0x2000 -> data_addr_ok for the load stays 0 until after bvalid; arvalid never overlaps W_RESP; load rdata is returned correctly.
- arready held 0 for 5 cycles -> araddr/arid/arsize stable and arvalid held high throughout; no second addr_ok issued.
- resetn=0 asserted while in R_WAIT -> next cycle arvalid=rready=awvalid=wvalid=bready=0; a late rvalid produces no data_ok.

Source files
------------

// File: rtl/sram_axi_bridge_arb.sv
// SRAM-like to AXI bridge with fetch/data arbitration.
// One read and one write may be outstanding at a time. Data reads take
// priority over fetches unless a store is in flight, in which case the data
// read waits until the store's B response has been seen.
//
// state  | meaning
// R_IDLE | no read outstanding, arbitrate fetch vs data read
// R_AR   | arvalid held with latched address until arready
// R_WAIT | rready high, waiting for the single R beat
// W_IDLE | no write outstanding, accept a store if no data read is held
// W_ADDR | awvalid/wvalid raised, each drops on its own ready
// W_RESP | bready high, waiting for bvalid
module sram_axi_bridge_arb #(
  parameter logic [3:0] ARID_INST = 4'd0,
  parameter logic [3:0] ARID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

  rstate_t     r_rstate, w_rstate_nxt;
  wstate_t     r_wstate, w_wstate_nxt;

  logic [31:0] r_araddr;
  logic [1:0]  r_arsize;
  logic [3:0]  r_arid;
  logic        r_rowner_data;

  logic [31:0] r_awaddr;
  logic [1:0]  r_awsize;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic        r_b_ok;

  logic        w_rd_sel_data;
  logic        w_rd_sel_inst;
  logic        w_wr_acc;
  logic        w_r_done;
  logic        w_rd_data_ok;

  // Read FSM next state and fetch/data arbitration in R_IDLE.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_rd_sel_data = 1'b0;
    w_rd_sel_inst = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (resetn) begin
          if (data_req && !data_wr && r_wstate == W_IDLE) begin
            w_rd_sel_data = 1'b1;
          end else if (inst_req) begin
            w_rd_sel_inst = 1'b1;
          end
          if (w_rd_sel_data || w_rd_sel_inst) begin
            w_rstate_nxt = R_AR;
          end
        end
      end
      R_AR:    if (arready) w_rstate_nxt = R_WAIT;
      R_WAIT:  if (rvalid)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_nxt;
  end

  // Latch the accepted read request; held stable through R_AR.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_araddr      <= 32'd0;
      r_arsize      <= 2'd0;
      r_arid        <= 4'd0;
      r_rowner_data <= 1'b0;
    end else if (w_rd_sel_data) begin
      r_araddr      <= data_addr;
      r_arsize      <= data_size;
      r_arid        <= ARID_DATA;
      r_rowner_data <= 1'b1;
    end else if (w_rd_sel_inst) begin
      r_araddr      <= inst_addr;
      r_arsize      <= inst_size;
      r_arid        <= ARID_INST;
      r_rowner_data <= 1'b0;
    end
  end

  // Write FSM next state; a store is held off while a data read is in flight.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_acc     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (resetn && data_req && data_wr &&
            !(r_rstate != R_IDLE && r_rowner_data)) begin
          w_wr_acc     = 1'b1;
          w_wstate_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        if ((!r_aw_pend || awready) && (!r_w_pend || wready)) begin
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP:  if (bvalid) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_nxt;
  end

  // Store payload latch and independent AW/W valid tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_awaddr  <= 32'd0;
      r_awsize  <= 2'd0;
      r_wstrb   <= 4'd0;
      r_wdata   <= 32'd0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else if (w_wr_acc) begin
      r_awaddr  <= data_addr;
      r_awsize  <= data_size;
      r_wstrb   <= data_wstrb;
      r_wdata   <= data_wdata;
      r_aw_pend <= 1'b1;
      r_w_pend  <= 1'b1;
    end else if (r_wstate == W_ADDR) begin
      if (awready) r_aw_pend <= 1'b0;
      if (wready)  r_w_pend  <= 1'b0;
    end
  end

  // Store completion is reported the cycle after the B handshake.
  always_ff @(posedge clk) begin
    if (!resetn) r_b_ok <= 1'b0;
    else         r_b_ok <= (r_wstate == W_RESP) && bvalid;
  end

  assign w_r_done     = (r_rstate == R_WAIT) && rvalid;
  assign w_rd_data_ok = w_r_done && (rid == ARID_DATA);

  assign inst_addr_ok = w_rd_sel_inst;
  assign inst_data_ok = w_r_done && (rid == ARID_INST);
  assign inst_rdata   = rdata;

  assign data_addr_ok = w_rd_sel_data || w_wr_acc;
  assign data_data_ok = w_rd_data_ok || r_b_ok;
  assign data_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = {1'b0, r_arsize};
  assign arvalid = (r_rstate == R_AR);
  assign rready  = (r_rstate == R_WAIT);

  assign awaddr  = r_awaddr;
  assign awsize  = {1'b0, r_awsize};
  assign awvalid = r_aw_pend;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wvalid  = r_w_pend;
  assign bready  = (r_wstate == W_RESP);

endmodule

// File: tb/tb_sram_axi_bridge_arb.sv
// Directed bench for sram_axi_bridge_arb: an arbitration vector table plus
// hand-written multi-cycle sequences for stalls, hazards and reset.
module tb_sram_axi_bridge_arb;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  sram_axi_bridge_arb dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req   = 1'b0;
    inst_size  = 2'd2;
    inst_addr  = 32'h1c00_0000;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_wstrb = 4'hf;
    data_addr  = 32'h0000_1000;
    data_wdata = 32'd0;
    arready    = 1'b0;
    rid        = 4'd0;
    rdata      = 32'd0;
    rvalid     = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  typedef struct {
    string       name;
    bit          inst_req;
    bit          data_req;
    bit          data_wr;
    bit          e_inst_ok;
    bit          e_data_ok;
    bit          e_arvalid;
    logic [3:0]  e_arid;
    logic [31:0] e_araddr;
    bit          e_awvalid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"none",       0, 0, 0, 0, 0, 0, 4'd0, 32'h0000_0000, 0};
    vecs[1] = '{"inst_rd",    1, 0, 0, 1, 0, 1, 4'd0, 32'h1c00_0000, 0};
    vecs[2] = '{"data_rd",    0, 1, 0, 0, 1, 1, 4'd1, 32'h0000_1000, 0};
    vecs[3] = '{"both_rd",    1, 1, 0, 0, 1, 1, 4'd1, 32'h0000_1000, 0};
    vecs[4] = '{"data_wr",    0, 1, 1, 0, 1, 0, 4'd0, 32'h0000_0000, 1};
    vecs[5] = '{"inst_wr",    1, 1, 1, 1, 1, 1, 4'd0, 32'h1c00_0000, 1};

    // Reset state, with requests asserted during reset.
    resetn = 1'b0;
    clear_inputs();
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
    step();
    #1;
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);

    // Arbitration table from idle.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      inst_req = vecs[i].inst_req;
      data_req = vecs[i].data_req;
      data_wr  = vecs[i].data_wr;
      #1;
      chk({vecs[i].name, "_inst_addr_ok"}, inst_addr_ok, vecs[i].e_inst_ok);
      chk({vecs[i].name, "_data_addr_ok"}, data_addr_ok, vecs[i].e_data_ok);
      step();
      inst_req = 1'b0;
      data_req = 1'b0;
      #1;
      chk({vecs[i].name, "_arvalid"}, arvalid, vecs[i].e_arvalid);
      chk({vecs[i].name, "_arid"}, arid, vecs[i].e_arid);
      chk({vecs[i].name, "_araddr"}, araddr, vecs[i].e_araddr);
      chk({vecs[i].name, "_awvalid"}, awvalid, vecs[i].e_awvalid);
    end

    // Fetch read with R three cycles after the AR handshake.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; arready = 1'b1;
    #1;
    chk("A_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 1'b0;
    #1;
    chk("A_arvalid", arvalid, 1);
    chk("A_arid", arid, 0);
    chk("A_arsize", arsize, 3'b010);
    step();
    arready = 1'b0;
    #1;
    chk("A_rready", rready, 1);
    chk("A_arvalid_low", arvalid, 0);
    step();
    chk("A_no_early_ok", inst_data_ok, 0);
    step();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C;
    #1;
    chk("A_inst_data_ok", inst_data_ok, 1);
    chk("A_inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk("A_data_data_ok", data_data_ok, 0);
    step();
    rvalid = 1'b0;
    #1;
    chk("A_inst_data_ok_pulse", inst_data_ok, 0);
    chk("A_rready_low", rready, 0);

    // Simultaneous fetch and data read: data wins, fetch follows.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
    #1;
    chk("B_data_addr_ok", data_addr_ok, 1);
    chk("B_inst_addr_ok", inst_addr_ok, 0);
    step();
    data_req = 1'b0; arready = 1'b1;
    #1;
    chk("B_arid_data", arid, 1);
    chk("B_araddr_data", araddr, 32'h0000_1000);
    chk("B_inst_wait_ar", inst_addr_ok, 0);
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("B_data_data_ok", data_data_ok, 1);
    chk("B_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("B_inst_wait_r", inst_addr_ok, 0);
    step();
    rvalid = 1'b0;
    #1;
    chk("B_inst_addr_ok_after", inst_addr_ok, 1);
    step();
    inst_req = 1'b0; arready = 1'b1;
    #1;
    chk("B_arid_inst", arid, 0);
    chk("B_araddr_inst", araddr, 32'h1c00_0004);
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_2222;
    #1;
    chk("B_inst_data_ok", inst_data_ok, 1);
    chk("B_inst_rdata", inst_rdata, 32'h1111_2222);
    step();
    rvalid = 1'b0;

    // Store: wready immediate, awready two cycles late.
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_3000;
    data_wstrb = 4'b0011; data_wdata = 32'h1234_ABCD;
    #1;
    chk("C_data_addr_ok", data_addr_ok, 1);
    step();
    data_req = 1'b0; wready = 1'b1;
    #1;
    chk("C_awvalid1", awvalid, 1);
    chk("C_wvalid1", wvalid, 1);
    chk("C_wstrb", wstrb, 4'b0011);
    chk("C_wdata", wdata, 32'h1234_ABCD);
    chk("C_awaddr", awaddr, 32'h0000_3000);
    chk("C_awsize", awsize, 3'b010);
    step();
    wready = 1'b0;
    #1;
    chk("C_awvalid2", awvalid, 1);
    chk("C_wvalid2", wvalid, 0);
    step();
    awready = 1'b1;
    #1;
    chk("C_awvalid3", awvalid, 1);
    step();
    awready = 1'b0;
    #1;
    chk("C_awvalid_low", awvalid, 0);
    chk("C_bready", bready, 1);
    chk("C_no_early_ok", data_data_ok, 0);
    step();
    bvalid = 1'b1;
    #1;
    chk("C_ok_not_in_b_cycle", data_data_ok, 0);
    step();
    bvalid = 1'b0;
    #1;
    chk("C_data_data_ok", data_data_ok, 1);
    chk("C_bready_low", bready, 0);
    step();
    chk("C_data_data_ok_pulse", data_data_ok, 0);

    // Load to the address of an outstanding store waits for B.
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_2000;
    data_wdata = 32'hCAFE_F00D;
    #1;
    chk("D_store_addr_ok", data_addr_ok, 1);
    step();
    data_wr = 1'b0; awready = 1'b1; wready = 1'b1;
    #1;
    chk("D_load_blocked_addr", data_addr_ok, 0);
    step();
    awready = 1'b0; wready = 1'b0;
    #1;
    chk("D_load_blocked_resp", data_addr_ok, 0);
    chk("D_no_ar_in_resp", arvalid, 0);
    step();
    bvalid = 1'b1;
    #1;
    chk("D_load_blocked_b", data_addr_ok, 0);
    chk("D_no_ar_in_b", arvalid, 0);
    step();
    bvalid = 1'b0;
    #1;
    chk("D_load_addr_ok", data_addr_ok, 1);
    chk("D_store_done", data_data_ok, 1);
    step();
    data_req = 1'b0; arready = 1'b1;
    #1;
    chk("D_arvalid", arvalid, 1);
    chk("D_araddr", araddr, 32'h0000_2000);
    chk("D_arid", arid, 1);
    chk("D_bready_off", bready, 0);
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h55AA_00FF;
    #1;
    chk("D_load_ok", data_data_ok, 1);
    chk("D_load_rdata", data_rdata, 32'h55AA_00FF);
    step();
    rvalid = 1'b0;

    // AR stall: address fields stable, no second acceptance.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1c00_0010; inst_size = 2'd1;
    #1;
    chk("E_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_addr = 32'h1c00_0020; inst_size = 2'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("E_arvalid_hold", arvalid, 1);
      chk("E_araddr_hold", araddr, 32'h1c00_0010);
      chk("E_arid_hold", arid, 0);
      chk("E_arsize_hold", arsize, 3'b001);
      chk("E_no_second_ok", inst_addr_ok, 0);
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("E_in_wait_no_ok", inst_addr_ok, 0);
    chk("E_rready", rready, 1);

    // Reset while in R_WAIT with a store stuck in W_ADDR.
    do_reset();
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; arready = 1'b1;
    step();
    inst_req = 1'b0; data_req = 1'b0;
    step();
    arready = 1'b0;
    #1;
    chk("F_pre_rready", rready, 1);
    chk("F_pre_awvalid", awvalid, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h7777_7777;
    #1;
    chk("F_arvalid", arvalid, 0);
    chk("F_rready", rready, 0);
    chk("F_awvalid", awvalid, 0);
    chk("F_wvalid", wvalid, 0);
    chk("F_bready", bready, 0);
    chk("F_late_inst_ok", inst_data_ok, 0);
    chk("F_late_data_ok", data_data_ok, 0);
    step();
    rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
